// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapped around a simple dual-port RAM with a registered read port.
// Upstream valid/ready writes go straight into the RAM. A 2-entry skid buffer absorbs
// the RAM's one-cycle read latency and presents a valid/ready read stream downstream.
// Both RAM clocks are expected to be tied to clk.
module ram_fifo_ctrl #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  // Upstream write stream
  input  logic               wr_valid,
  input  logic [D_WIDTH-1:0] wr_data,
  output logic               wr_ready,
  // Downstream read stream
  output logic               rd_valid,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic               rd_ready,
  // Total words held: RAM + in-flight read + skid buffer
  output logic [A_WIDTH:0]   level,
  // RAM write port
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  // RAM read port (data returns one cycle after the address)
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  // Count value meaning "RAM completely full" (DEPTH = 2**A_WIDTH).
  localparam logic [A_WIDTH:0]   DepthCnt = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]   CntOne   = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] PtrOne   = {{(A_WIDTH-1){1'b0}}, 1'b1};

  // RAM-side state
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   ram_count_q, ram_count_d;
  logic               inflight_q, inflight_d;

  // Skid buffer state
  logic [D_WIDTH-1:0] obuf_q [2];
  logic               obuf_head_q, obuf_head_d;
  logic               obuf_tail_q, obuf_tail_d;
  logic [1:0]         obuf_count_q, obuf_count_d;

  // Handshake and control strobes
  logic       push;
  logic       pop;
  logic       issue;
  logic       capture;
  logic [2:0] obuf_claim;

  // Handshakes, issue decision and the RAM port drive.
  always_comb begin
    // Gating with rst_n keeps wr_ready low for the whole reset window, not just after it.
    wr_ready = rst_n && !flush && (ram_count_q != DepthCnt);
    rd_valid = !flush && (obuf_count_q != 2'd0);
    rd_data  = obuf_q[obuf_head_q];

    push    = wr_valid && wr_ready;
    pop     = rd_valid && rd_ready;
    capture = inflight_q && !flush;

    // Skid slots spoken for next cycle: words already held plus the one returning,
    // minus the one leaving now. Issuing is only safe while this stays below 2.
    obuf_claim = {2'b00, inflight_q} + {1'b0, obuf_count_q} - {2'b00, pop};
    // ram_count_q is registered, so a word written this cycle is never read this cycle.
    issue      = (ram_count_q != '0) && (obuf_claim < 3'd2) && !flush;

    ram_address_write = wr_ptr_q;
    ram_data_write    = wr_data;
    ram_write_enable  = push;
    ram_address_read  = rd_ptr_q;

    level = ram_count_q
          + {{A_WIDTH{1'b0}}, inflight_q}
          + {{(A_WIDTH-1){1'b0}}, obuf_count_q};
  end

  // Next-state for pointers, counts and skid-buffer bookkeeping; flush wins over everything.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    inflight_d   = inflight_q;
    obuf_head_d  = obuf_head_q;
    obuf_tail_d  = obuf_tail_q;
    obuf_count_d = obuf_count_q;

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      ram_count_d  = '0;
      inflight_d   = 1'b0;
      obuf_head_d  = 1'b0;
      obuf_tail_d  = 1'b0;
      obuf_count_d = 2'd0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push)  wr_ptr_d = wr_ptr_q + PtrOne;
      if (issue) rd_ptr_d = rd_ptr_q + PtrOne;

      unique case ({push, issue})
        2'b10:   ram_count_d = ram_count_q + CntOne;
        2'b01:   ram_count_d = ram_count_q - CntOne;
        default: ram_count_d = ram_count_q;
      endcase

      inflight_d = issue;

      if (capture) obuf_tail_d = ~obuf_tail_q;
      if (pop)     obuf_head_d = ~obuf_head_q;

      unique case ({capture, pop})
        2'b10:   obuf_count_d = obuf_count_q + 2'd1;
        2'b01:   obuf_count_d = obuf_count_q - 2'd1;
        default: obuf_count_d = obuf_count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      inflight_q   <= 1'b0;
      obuf_head_q  <= 1'b0;
      obuf_tail_q  <= 1'b0;
      obuf_count_q <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      inflight_q   <= inflight_d;
      obuf_head_q  <= obuf_head_d;
      obuf_tail_q  <= obuf_tail_d;
      obuf_count_q <= obuf_count_d;
    end
  end

  // Skid-buffer storage: the returning RAM word lands in the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
    end else if (capture) begin
      obuf_q[obuf_tail_q] <= ram_data_read;
    end
  end

`ifndef SYNTHESIS
  // Internal consistency checks for simulation.
  a_obuf_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    obuf_count_q != 2'd3);
  a_ram_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    ram_count_q <= DepthCnt);
  a_no_obuf_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && !pop && (obuf_count_q == 2'd2)));
  a_no_read_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(issue && (ram_count_q == '0)));
`endif

endmodule
